frame_score_ctrl: RTL

Frame-synchronous controller for the frame/score display datapath. Accepts score, ball depth and game-state updates from game logic through a valid/ready handshake and holds each update in a one-entry pending buffer. It commits pending data to the display-facing registers only at end of active frame, so the highlight frame and score digits never tear mid-frame. On a score change it sequences a blink of the score digits for a fixed number of frames.

---
 rtl/frame_score_ctrl_pkg.sv | 29 ++
 rtl/flash_seq.sv | 65 ++++++
 rtl/frame_score_ctrl.sv | 126 ++++++++++++
 3 files changed

// File: rtl/frame_score_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// frame_score_ctrl_pkg
// Shared display definitions for the frame/score display datapath.
//   H_LAST / V_LAST : last active pixel column / row (also used by VGA timing)
//   SCORE_W         : width of a score digit value
//   DATA_W          : width of ball depth and game state
//   flash_state_e   : score flash sequencer states
//   disp_data_t     : one complete display update (both scores, depth, state)
// ----------------------------------------------------------------------------
package frame_score_ctrl_pkg;

    localparam int unsigned H_LAST  = 639;
    localparam int unsigned V_LAST  = 479;
    localparam int unsigned SCORE_W = 4;
    localparam int unsigned DATA_W  = 16;

    typedef enum logic {
        NORMAL = 1'b0,
        FLASH  = 1'b1
    } flash_state_e;

    typedef struct packed {
        logic [SCORE_W-1:0] your_score;
        logic [SCORE_W-1:0] their_score;
        logic [DATA_W-1:0]  ball_z;
        logic [DATA_W-1:0]  game_state;
    } disp_data_t;

endpackage

// File: rtl/flash_seq.sv
// ----------------------------------------------------------------------------
// flash_seq
// Blinks the score digits for FLASH_FRAMES frames after a score change.
// A further score change while blinking restarts the full blink period.
//   clk, rst     : clock, synchronous active-high reset
//   frame_end    : one-cycle pulse at end of active frame
//   score_change : a commit at this frame_end changes either score
//   score_blank  : registered; high while the score digits are suppressed
// ----------------------------------------------------------------------------
module flash_seq
    import frame_score_ctrl_pkg::*;
#(
    parameter int unsigned FLASH_FRAMES = 60,
    parameter int unsigned BLINK_PERIOD = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic frame_end,
    input  logic score_change,
    output logic score_blank
);

    // Bit of the down-counter that flips every BLINK_PERIOD frames.
    localparam int         BLINK_BIT  = $clog2(BLINK_PERIOD);
    localparam logic [7:0] FLASH_LOAD = 8'(FLASH_FRAMES);

    flash_state_e state_q, state_d;
    logic [7:0]   flash_cnt_q, flash_cnt_d;
    logic         score_blank_q, score_blank_d;

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        state_d     = state_q;
        flash_cnt_d = flash_cnt_q;
        if (frame_end) begin
            if (score_change) begin
                state_d     = FLASH;
                flash_cnt_d = FLASH_LOAD;
            end else if (state_q == FLASH) begin
                flash_cnt_d = flash_cnt_q - 8'd1;
                if (flash_cnt_d == 8'd0) begin
                    state_d = NORMAL;
                end
            end
        end
        // Computed from next-state so the registered output lines up with state/count.
        score_blank_d = (state_d == FLASH) && flash_cnt_d[BLINK_BIT];
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so all flops update together from pre-edge values.
        if (rst) begin
            state_q       <= NORMAL;
            flash_cnt_q   <= 8'd0;
            score_blank_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            flash_cnt_q   <= flash_cnt_d;
            score_blank_q <= score_blank_d;
        end
    end

    assign score_blank = score_blank_q;

endmodule

// File: rtl/frame_score_ctrl.sv
// ----------------------------------------------------------------------------
// frame_score_ctrl
// Frame-synchronous controller for the score display. Game logic offers
// updates over a valid/ready handshake into a one-entry pending buffer; the
// buffer is committed to the display registers only at end of active frame so
// nothing tears mid-frame. Score changes trigger a blink sequence (flash_seq).
//   clk, rst                 : clock, synchronous active-high reset
//   vga_ready, pixel_x/y     : VGA timing strobe and current pixel position
//   upd_valid / upd_ready    : update handshake, accepted when both high
//   upd_*                    : offered scores, ball depth, game state
//   your_score .. game_state : committed display values
//   score_blank              : suppress score drawing (blink phase)
//   frame_end                : one-cycle pulse at end of active frame
//   frame_count              : completed-frame counter (wraps)
// ----------------------------------------------------------------------------
module frame_score_ctrl
    import frame_score_ctrl_pkg::SCORE_W,
           frame_score_ctrl_pkg::DATA_W,
           frame_score_ctrl_pkg::disp_data_t;
#(
    parameter int unsigned H_LAST       = frame_score_ctrl_pkg::H_LAST,
    parameter int unsigned V_LAST       = frame_score_ctrl_pkg::V_LAST,
    parameter int unsigned FLASH_FRAMES = 60,
    parameter int unsigned BLINK_PERIOD = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               vga_ready,
    input  logic [15:0]        pixel_x,
    input  logic [15:0]        pixel_y,
    input  logic               upd_valid,
    output logic               upd_ready,
    input  logic [SCORE_W-1:0] upd_your_score,
    input  logic [SCORE_W-1:0] upd_their_score,
    input  logic [DATA_W-1:0]  upd_ball_z,
    input  logic [DATA_W-1:0]  upd_game_state,
    output logic [SCORE_W-1:0] your_score,
    output logic [SCORE_W-1:0] their_score,
    output logic [DATA_W-1:0]  ball_z,
    output logic [DATA_W-1:0]  game_state,
    output logic               score_blank,
    output logic               frame_end,
    output logic [15:0]        frame_count
);

    logic       pending_q, pending_d;
    disp_data_t buf_q, buf_d;
    disp_data_t disp_q, disp_d;
    logic [15:0] frame_count_q, frame_count_d;

    disp_data_t upd_data;
    logic       accept;
    logic       commit;
    logic       score_change;

    assign frame_end = vga_ready && (pixel_x == 16'(H_LAST)) && (pixel_y == 16'(V_LAST));

    // Ready only when the buffer is free; an accept can therefore never
    // coincide with a commit, so data accepted at frame_end waits a full frame.
    assign upd_ready = !pending_q && !rst;
    assign accept    = upd_valid && upd_ready;
    assign commit    = frame_end && pending_q;

    assign upd_data = '{your_score:  upd_your_score,
                        their_score: upd_their_score,
                        ball_z:      upd_ball_z,
                        game_state:  upd_game_state};

    // Only score differences restart the blink; depth/state-only commits do not.
    assign score_change = commit &&
                          ((buf_q.your_score  != disp_q.your_score) ||
                           (buf_q.their_score != disp_q.their_score));

    always_comb begin
        pending_d     = pending_q;
        buf_d         = buf_q;
        disp_d        = disp_q;
        frame_count_d = frame_count_q;
        if (frame_end) begin
            frame_count_d = frame_count_q + 16'd1;
            if (pending_q) begin
                disp_d    = buf_q;
                pending_d = 1'b0;
            end
        end
        if (accept) begin
            buf_d     = upd_data;
            pending_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending_q     <= 1'b0;
            disp_q        <= '0;
            frame_count_q <= 16'd0;
        end else begin
            pending_q     <= pending_d;
            disp_q        <= disp_d;
            frame_count_q <= frame_count_d;
        end
    end

    // NOTE: buffer data is not reset; it is never observed unless pending_q is set.
    always_ff @(posedge clk) begin
        buf_q <= buf_d;
    end

    flash_seq #(
        .FLASH_FRAMES (FLASH_FRAMES),
        .BLINK_PERIOD (BLINK_PERIOD)
    ) u_flash_seq (
        .clk          (clk),
        .rst          (rst),
        .frame_end    (frame_end),
        .score_change (score_change),
        .score_blank  (score_blank)
    );

    assign your_score  = disp_q.your_score;
    assign their_score = disp_q.their_score;
    assign ball_z      = disp_q.ball_z;
    assign game_state  = disp_q.game_state;
    assign frame_count = frame_count_q;

endmodule
